mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbiter and sequencer that shares the single-ported instruction/data memory between the fetch stage and the memory-access stage of the pipelined CPU. It accepts one request at a time from each side, grants by fixed priority (data over fetch) with an optional anti-starvation rule, drives the memory strobes until the memory reports ready, and returns read data with a one-cycle acknowledge. Sits between the CPU core's fetch/memory stages and the external memory port; the core stalls a stage while its request is outstanding and unacknowledged.

## Interface

- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_STREAK, 4, consecutive data grants allowed while fetch waits (used only with fairness enabled; legal range 1..15)

- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high; all state and outputs to reset values immediately
- if_req  in  1  fetch request, held high until if_ack
- if_addr  in  ADDR_W  fetch address, stable while if_req high
- if_rdata  out  DATA_W  fetched word, valid only while if_ack high
- if_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, held high until d_ack
- d_we  in  1  1 = write, 0 = read; stable while d_req high
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read word, valid only while d_ack high
- d_ack  out  1  one-cycle data completion pulse (reads and writes)
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rd  out  1  memory read strobe, registered
- mem_wr  out  1  memory write strobe, registered
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready high
- mem_ready  in  1  memory completes current access this cycle
- busy  out  1  high in any state other than IDLE

## Operation

- States: IDLE, FETCH, DATA, RESP. Reset state IDLE.
- IDLE: if no request, stay. Otherwise pick winner: d_req beats if_req, except fairness override (Configuration). Latch winner's address, d_we, d_wdata into mem_* registers; go to FETCH (mem_rd=1) or DATA (mem_rd=~d_we, mem_wr=d_we).
- FETCH/DATA: hold mem_* constant; when mem_ready=1, capture mem_rdata into response register (reads only; writes leave it unchanged), drop mem_rd/mem_wr, go to RESP.
- RESP: assert winner's ack for exactly one cycle, drive captured word on its rdata; go to IDLE unconditionally. Other requester's ack stays 0.
- Requests are sampled only in IDLE; changes to any requester input during FETCH/DATA/RESP are ignored.
- Request withdrawn before ack: access already launched completes, ack still pulses; requester must ignore it.
- Both acks never high together; mem_rd and mem_wr never high together.
- if_rdata/d_rdata outside ack cycles: hold last captured value (no X).

## Timing

- Reset values: if_ack=0, d_ack=0, mem_rd=0, mem_wr=0, busy=0, mem_addr=0, mem_wdata=0, if_rdata=0, d_rdata=0, streak counter=0.
- Minimum latency: req high in IDLE cycle N → strobe high cycle N+1 → mem_ready in N+1 → ack in N+2 → IDLE in N+3. Each wait cycle of mem_ready adds one cycle.
- Peak throughput: one access per 3 cycles.
- Requester sees ack at edge ending RESP and drops or changes req for the following IDLE cycle; a req still high in IDLE is treated as a new request.
- mem_ready ignored in IDLE and RESP.
- rst asserted mid-access: strobes and acks drop asynchronously, in-flight access abandoned, no ack issued after release.

## Configuration

- ARB_FAIRNESS_EN defined: 4-bit streak counter. At each IDLE decision where d_req wins while if_req=1, counter increments (saturating at MAX_STREAK). When both request and counter==MAX_STREAK, fetch wins instead. Counter clears on any fetch grant and on any decision with if_req=0.
- Not defined: strict data priority, no counter; fetch can starve indefinitely under continuous d_req.

## Test plan

- Single fetch, if_addr=0x100, mem_ready same cycle, mem_rdata=0x8C220004 → if_ack pulse 2 cycles after req with if_rdata=0x8C220004; mem_rd high exactly 1 cycle, mem_addr=0x100.
- Data write d_addr=0x40, d_wdata=0xDEADBEEF, mem_ready after 3 wait cycles → mem_wr high 4 cycles, mem_rd=0, d_ack pulse in cycle after mem_ready, if_ack=0.
- Simultaneous if_req and d_req (read 0x44) → data served first, then fetch starts in the IDLE cycle after d_ack; no overlap of strobes.
- With ARB_FAIRNESS_EN, MAX_STREAK=4, d_req and if_req held continuously → grant order D,D,D,D,F,D,D,D,D,F; without macro → fetch never granted over 20 accesses.
- rst pulsed during DATA with mem_ready low → mem_wr/mem_rd/acks 0 immediately, busy=0; after release, pending if_req is granted normally and no stale d_ack appears.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch stage
// and the data (load/store) stage. Data beats fetch by fixed priority; with
// the ARB_FAIRNESS_EN macro defined, a streak counter lets fetch win after
// MAX_STREAK consecutive data grants taken while fetch was waiting.
//
// state | meaning
// IDLE  | no access in flight, arbitration happens here
// FETCH | fetch read on the memory port, waiting for mem_ready
// DATA  | data read or write on the memory port, waiting for mem_ready
// RESP  | one-cycle acknowledge to the winner, then back to IDLE
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    logic   grant_d;

    if (MAX_STREAK < 1 || MAX_STREAK > 15) begin : g_bad_max_streak
        $error("mem_port_arbiter: MAX_STREAK must be in 1..15");
    end

`ifdef ARB_FAIRNESS_EN
    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    logic [3:0] streak;
    logic       fetch_due;

    // Fetch has waited through MAX_STREAK data grants and gets this slot.
    assign fetch_due = if_req && (streak == STREAK_MAX);
    assign grant_d   = d_req && !fetch_due;

    // Count data grants taken while fetch was also asking; any other decision clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= 4'd0;
        end else if (state == IDLE && (d_req || if_req)) begin
            if (grant_d && if_req) begin
                streak <= (streak == STREAK_MAX) ? streak : streak + 4'd1;
            end else begin
                streak <= 4'd0;
            end
        end
    end
`else
    assign grant_d = d_req;
`endif

    assign busy = (state != IDLE);

    // Arbitration, memory strobe sequencing, response capture and acks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_rd    <= ~d_we;
                        mem_wr    <= d_we;
                        state     <= DATA;
                    end else if (if_req) begin
                        mem_addr  <= if_addr;
                        mem_rd    <= 1'b1;
                        mem_wr    <= 1'b0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ready) begin
                        mem_rd   <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_ack   <= 1'b1;
                        state    <= RESP;
                    end
                end
                DATA: begin
                    if (mem_ready) begin
                        // Writes leave the last read word in place.
                        if (mem_rd) begin
                            d_rdata <= mem_rdata;
                        end
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        d_ack  <= 1'b1;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
